// File: rtl/diagv2_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : diagv2_test_sequencer
// Purpose  : Runs a suite of diagv2 test programs back to back (load, reset,
//            run, halt on ecall), classifies each exit and keeps pass/fail tallies.
// Revision : 1.0 - initial release
// ============================================================================
module diagv2_test_sequencer #(
    parameter int NUM_TESTS    = 50,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 100000,
    parameter int XLEN         = 64,
    parameter int EXIT_CODE    = 93,
    localparam int IDX_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CNT_W       = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             core_reset,
    output logic             core_run,
    output logic [IDX_W-1:0] prog_sel,
    output logic             load_req,
    input  logic             load_done,
    input  logic             ecall,
    input  logic [XLEN-1:0]  syscall,
    input  logic [XLEN-1:0]  arg0,
    output logic             result_valid,
    output logic [1:0]       result_code,
    output logic [IDX_W-1:0] result_idx,
    output logic [XLEN-1:0]  result_arg,
    output logic [CNT_W-1:0] passed,
    output logic [CNT_W-1:0] failed,
    output logic             invalid_seen,
    output logic             timeout_seen,
    output logic             done
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int CYC_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(NUM_TESTS - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0]  c_CYC_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]   c_EXIT      = XLEN'(EXIT_CODE);

    localparam logic [1:0] c_CODE_PASS    = 2'b00;
    localparam logic [1:0] c_CODE_EXIT_NZ = 2'b01;
    localparam logic [1:0] c_CODE_INVALID = 2'b10;
    localparam logic [1:0] c_CODE_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RST_HOLD = 3'd2,
        S_RUN      = 3'd3,
        S_NEXT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            state_q,        state_d;
    logic [IDX_W-1:0]  prog_sel_q,     prog_sel_d;
    logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
    logic [CYC_W-1:0]  cyc_cnt_q,      cyc_cnt_d;
    logic [1:0]        result_code_q,  result_code_d;
    logic [IDX_W-1:0]  result_idx_q,   result_idx_d;
    logic [XLEN-1:0]   result_arg_q,   result_arg_d;
    logic [CNT_W-1:0]  passed_q,       passed_d;
    logic [CNT_W-1:0]  failed_q,       failed_d;
    logic              invalid_seen_q, invalid_seen_d;
    logic              timeout_seen_q, timeout_seen_d;

    logic       w_is_exit;
    logic [1:0] w_code;

    assign w_is_exit = (syscall == c_EXIT);

    always_comb begin
        state_d        = state_q;
        prog_sel_d     = prog_sel_q;
        hold_cnt_d     = hold_cnt_q;
        cyc_cnt_d      = cyc_cnt_q;
        result_code_d  = result_code_q;
        result_idx_d   = result_idx_q;
        result_arg_d   = result_arg_q;
        passed_d       = passed_q;
        failed_d       = failed_q;
        invalid_seen_d = invalid_seen_q;
        timeout_seen_d = timeout_seen_q;
        core_reset     = 1'b1;
        core_run       = 1'b0;
        load_req       = 1'b0;
        result_valid   = 1'b0;
        done           = 1'b0;
        w_code         = c_CODE_TIMEOUT;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    passed_d       = '0;
                    failed_d       = '0;
                    invalid_seen_d = 1'b0;
                    timeout_seen_d = 1'b0;
                    prog_sel_d     = '0;
                    state_d        = S_LOAD;
                end
            end

            S_LOAD: begin
                load_req = 1'b1;
                if (load_done) begin
                    hold_cnt_d = '0;
                    state_d    = S_RST_HOLD;
                end
            end

            S_RST_HOLD: begin
                core_run = 1'b1;
                if (hold_cnt_q == c_HOLD_LAST) begin
                    cyc_cnt_d = '0;
                    state_d   = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                // Halt in the same cycle ecall is seen so it never retires past itself.
                core_reset = 1'b0;
                core_run   = !ecall;
                cyc_cnt_d  = cyc_cnt_q + CYC_W'(1);
                if (ecall || (cyc_cnt_q == c_CYC_LAST)) begin
                    if (ecall) begin
                        if (w_is_exit) begin
                            w_code = (arg0 == '0) ? c_CODE_PASS : c_CODE_EXIT_NZ;
                        end else begin
                            w_code = c_CODE_INVALID;
                        end
                        result_arg_d = arg0;
                    end else begin
                        w_code       = c_CODE_TIMEOUT;
                        result_arg_d = '0;
                    end
                    result_code_d = w_code;
                    result_idx_d  = prog_sel_q;
                    if (w_code == c_CODE_PASS) begin
                        passed_d = passed_q + CNT_W'(1);
                    end else begin
                        failed_d = failed_q + CNT_W'(1);
                    end
                    if (w_code == c_CODE_INVALID) begin
                        invalid_seen_d = 1'b1;
                    end
                    if (w_code == c_CODE_TIMEOUT) begin
                        timeout_seen_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                result_valid = 1'b1;
                if (prog_sel_q == c_LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    prog_sel_d = prog_sel_q + IDX_W'(1);
                    state_d    = S_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            prog_sel_q     <= '0;
            hold_cnt_q     <= '0;
            cyc_cnt_q      <= '0;
            result_code_q  <= '0;
            result_idx_q   <= '0;
            result_arg_q   <= '0;
            passed_q       <= '0;
            failed_q       <= '0;
            invalid_seen_q <= 1'b0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prog_sel_q     <= prog_sel_d;
            hold_cnt_q     <= hold_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            result_code_q  <= result_code_d;
            result_idx_q   <= result_idx_d;
            result_arg_q   <= result_arg_d;
            passed_q       <= passed_d;
            failed_q       <= failed_d;
            invalid_seen_q <= invalid_seen_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end

    assign prog_sel     = prog_sel_q;
    assign result_code  = result_code_q;
    assign result_idx   = result_idx_q;
    assign result_arg   = result_arg_q;
    assign passed       = passed_q;
    assign failed       = failed_q;
    assign invalid_seen = invalid_seen_q;
    assign timeout_seen = timeout_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_diagv2_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_diagv2_test_sequencer
// Purpose  : Self-checking bench; expected outputs follow from the scheduled test transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diagv2_test_sequencer;

    localparam int c_NT = 3;
    localparam int c_RC = 2;
    localparam int c_TO = 20;
    localparam int c_XL = 64;
    localparam int c_EC = 93;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             load_done;
    logic             ecall;
    logic [c_XL-1:0]  syscall;
    logic [c_XL-1:0]  arg0;
    logic             core_reset;
    logic             core_run;
    logic [1:0]       prog_sel;
    logic             load_req;
    logic             result_valid;
    logic [1:0]       result_code;
    logic [1:0]       result_idx;
    logic [c_XL-1:0]  result_arg;
    logic [1:0]       passed;
    logic [1:0]       failed;
    logic             invalid_seen;
    logic             timeout_seen;
    logic             done;

    diagv2_test_sequencer #(
        .NUM_TESTS    (c_NT),
        .RESET_CYCLES (c_RC),
        .TIMEOUT      (c_TO),
        .XLEN         (c_XL),
        .EXIT_CODE    (c_EC)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .core_reset   (core_reset),
        .core_run     (core_run),
        .prog_sel     (prog_sel),
        .load_req     (load_req),
        .load_done    (load_done),
        .ecall        (ecall),
        .syscall      (syscall),
        .arg0         (arg0),
        .result_valid (result_valid),
        .result_code  (result_code),
        .result_idx   (result_idx),
        .result_arg   (result_arg),
        .passed       (passed),
        .failed       (failed),
        .invalid_seen (invalid_seen),
        .timeout_seen (timeout_seen),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Expected output values for the current cycle
    bit          e_core_reset, e_core_run, e_load_req, e_valid, e_done, e_inv, e_to;
    int          e_prog_sel, e_code, e_idx, e_passed, e_failed;
    logic [63:0] e_arg;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_reset",   64'(core_reset),   64'(e_core_reset));
            chk("core_run",     64'(core_run),     64'(e_core_run));
            chk("load_req",     64'(load_req),     64'(e_load_req));
            chk("prog_sel",     64'(prog_sel),     64'(e_prog_sel));
            chk("result_valid", 64'(result_valid), 64'(e_valid));
            chk("result_code",  64'(result_code),  64'(e_code));
            chk("result_idx",   64'(result_idx),   64'(e_idx));
            chk("result_arg",   result_arg,        e_arg);
            chk("passed",       64'(passed),       64'(e_passed));
            chk("failed",       64'(failed),       64'(e_failed));
            chk("invalid_seen", 64'(invalid_seen), 64'(e_inv));
            chk("timeout_seen", 64'(timeout_seen), 64'(e_to));
            chk("done",         64'(done),         64'(e_done));
        end
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        start     = 1'b0;
        load_done = 1'b0;
        ecall     = 1'b0;
        syscall   = {$urandom, $urandom};
        arg0      = {$urandom, $urandom};
        e_valid   = 1'b0;
    endtask

    task automatic set_reset_exp();
        e_core_reset = 1'b1; e_core_run = 1'b0; e_load_req = 1'b0; e_valid = 1'b0;
        e_done = 1'b0; e_inv = 1'b0; e_to = 1'b0;
        e_prog_sel = 0; e_code = 0; e_idx = 0; e_arg = '0; e_passed = 0; e_failed = 0;
    endtask

    // reset was raised in the current cycle; the next edge must restore reset values
    task automatic reset_tail();
        reset = 1'b1;
        cyc_begin();
        reset = 1'b0;
        set_reset_exp();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            ecall = 1'($urandom);
        end
    endtask

    // Ends in the first LOAD cycle of program 0
    task automatic start_suite();
        cyc_begin();
        start = 1'b1;
        cyc_begin();
        e_done = 1'b0; e_passed = 0; e_failed = 0; e_inv = 1'b0; e_to = 1'b0;
        e_prog_sel = 0; e_load_req = 1'b1; e_core_reset = 1'b1; e_core_run = 1'b0;
    endtask

    // One program: entered in its first LOAD cycle, leaves in the first cycle of the
    // following LOAD or DONE. ecyc=0 or ecyc>TIMEOUT means no ecall (timeout).
    task automatic run_one(input int ld, input int ecyc, input logic [63:0] a7,
                           input logic [63:0] a0, input int abort_run);
        bit hit;
        hit = 1'b0;
        for (int d = 0; d <= ld; d++) begin
            if (d > 0) cyc_begin();
            e_load_req = 1'b1; e_core_reset = 1'b1; e_core_run = 1'b0;
            ecall     = 1'($urandom);
            start     = 1'($urandom);
            load_done = (d == ld);
        end
        for (int h = 0; h < c_RC; h++) begin
            cyc_begin();
            e_load_req = 1'b0; e_core_reset = 1'b1; e_core_run = 1'b1;
            ecall = 1'($urandom);
            start = 1'($urandom);
        end
        for (int k = 1; k <= c_TO; k++) begin
            cyc_begin();
            e_core_reset = 1'b0;
            start = 1'($urandom);
            if (k == abort_run) begin
                e_core_run = 1'b1;
                reset_tail();
                return;
            end
            if (k == ecyc) begin
                ecall = 1'b1; syscall = a7; arg0 = a0;
                e_core_run = 1'b0;
                hit = 1'b1;
                break;
            end
            e_core_run = 1'b1;
        end
        cyc_begin();
        e_core_reset = 1'b1; e_core_run = 1'b0; e_valid = 1'b1;
        if (hit) begin
            e_code = (a7 == 64'(c_EC)) ? ((a0 == 64'd0) ? 0 : 1) : 2;
            e_arg  = a0;
        end else begin
            e_code = 3;
            e_arg  = '0;
        end
        e_idx = e_prog_sel;
        if (e_code == 0) e_passed++; else e_failed++;
        if (e_code == 2) e_inv = 1'b1;
        if (e_code == 3) e_to = 1'b1;
        ecall = 1'($urandom);
        start = 1'($urandom);
        cyc_begin();
        if (e_prog_sel == c_NT - 1) begin
            e_done = 1'b1; e_load_req = 1'b0;
        end else begin
            e_prog_sel++; e_load_req = 1'b1;
        end
    endtask

    task automatic pin(input string name, input logic [63:0] act, input logic [63:0] exp);
        @(negedge clk);
        chk(name, act, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_done = 1'b0; ecall = 1'b0;
        syscall = '0; arg0 = '0;
        @(posedge clk);
        #1;
        set_reset_exp();
        chk_en = 1'b1;
        cyc_begin();
        reset = 1'b0;
        idle_cycles(2);

        // Suite A: pass, exit 7, invalid syscall
        start_suite();
        run_one(3, 5, 64'd93, 64'd0, 0);
        pin("pin_t0_passed",   64'(passed),   64'd1);
        pin("pin_t0_prog_sel", 64'(prog_sel), 64'd1);
        pin("pin_t0_load_req", 64'(load_req), 64'd1);
        run_one(0, 4, 64'd93, 64'd7, 0);
        pin("pin_t1_code",   64'(result_code), 64'd1);
        pin("pin_t1_arg",    result_arg,       64'd7);
        pin("pin_t1_failed", 64'(failed),      64'd1);
        run_one(1, 3, 64'd64, 64'd5, 0);
        pin("pin_a_done",    64'(done),         64'd1);
        pin("pin_a_passed",  64'(passed),       64'd1);
        pin("pin_a_failed",  64'(failed),       64'd2);
        pin("pin_a_invalid", 64'(invalid_seen), 64'd1);
        idle_cycles(3);

        // Suite B: ecall exactly on the timeout cycle, then a real timeout, then reset mid-RUN
        start_suite();
        pin("pin_b_cleared", 64'({passed, failed, invalid_seen}), 64'd0);
        run_one(2, c_TO, 64'd93, 64'd0, 0);
        pin("pin_b0_code",    64'(result_code),  64'd0);
        pin("pin_b0_timeout", 64'(timeout_seen), 64'd0);
        run_one(0, 0, 64'd0, 64'd0, 0);
        pin("pin_b1_code",    64'(result_code),  64'd3);
        pin("pin_b1_arg",     result_arg,        64'd0);
        pin("pin_b1_timeout", 64'(timeout_seen), 64'd1);
        run_one(1, 0, 64'd0, 64'd0, 3);
        pin("pin_rst_run_core_run", 64'(core_run), 64'd0);
        pin("pin_rst_run_failed",   64'(failed),   64'd0);
        idle_cycles(2);

        // Suite C: reset while LOAD is waiting
        start_suite();
        run_one(0, 2, 64'd93, 64'd0, 0);
        cyc_begin();
        e_load_req = 1'b1; e_core_reset = 1'b1; e_core_run = 1'b0;
        reset_tail();
        pin("pin_rst_load_req", 64'(load_req), 64'd0);
        pin("pin_rst_passed",   64'(passed),   64'd0);
        idle_cycles(1);

        // Randomized suites
        for (int s = 0; s < 8; s++) begin
            idle_cycles($urandom_range(0, 3));
            start_suite();
            for (int t = 0; t < c_NT; t++) begin
                logic [63:0] a7, a0;
                int ec;
                a7 = ($urandom_range(0, 2) != 0) ? 64'd93 : 64'($urandom_range(0, 127));
                a0 = ($urandom_range(0, 1) != 0) ? 64'd0 : {$urandom, $urandom};
                ec = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, c_TO + 3);
                run_one($urandom_range(0, 4), ec, a7, a0, 0);
            end
        end
        idle_cycles(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
